// File: rtl/ifft_butterfly_dif.sv
// Radix-2 inverse butterfly: A'=(X+Y)/2, B'=((X-Y)/2)*conj(W), Q8.8 data, Q1.15 twiddle.
// Four-stage streaming pipeline; one global enable derived from output back-pressure.
module ifft_butterfly_dif #(
    parameter int unsigned NBITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [NBITS-1:0] Xr,
    input  logic [NBITS-1:0] Xi,
    input  logic [NBITS-1:0] Yr,
    input  logic [NBITS-1:0] Yi,
    input  logic [NBITS-1:0] Wr,
    input  logic [NBITS-1:0] Wi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [NBITS-1:0] Ar,
    output logic [NBITS-1:0] Ai,
    output logic [NBITS-1:0] Br,
    output logic [NBITS-1:0] Bi,
    output logic             sat_flag,
    input  logic             sat_clr
);

    localparam int unsigned EW = NBITS + 1;
    localparam int unsigned BW = NBITS + 2;
    localparam int unsigned PW = 2 * NBITS;

    logic en;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ---------------------------------------------------------------- stage 1
    logic             s1_valid_q;
    logic             s1_last_q;
    logic [NBITS-1:0] s1_xr_q;
    logic [NBITS-1:0] s1_xi_q;
    logic [NBITS-1:0] s1_yr_q;
    logic [NBITS-1:0] s1_yi_q;
    logic [NBITS-1:0] s1_wr_q;
    logic [NBITS-1:0] s1_wi_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else if (en) begin
            s1_valid_q <= in_valid;
            s1_last_q  <= in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_xr_q <= Xr;
            s1_xi_q <= Xi;
            s1_yr_q <= Yr;
            s1_yi_q <= Yi;
            s1_wr_q <= Wr;
            s1_wi_q <= Wi;
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic signed [EW-1:0] s2_sum_r;
    logic signed [EW-1:0] s2_sum_i;
    logic signed [EW-1:0] s2_dif_r;
    logic signed [EW-1:0] s2_dif_i;
    logic [NBITS-1:0]     s2_ah_r_d;
    logic [NBITS-1:0]     s2_ah_i_d;
    logic [NBITS-1:0]     s2_dh_r_d;
    logic [NBITS-1:0]     s2_dh_i_d;

    assign s2_sum_r = $signed({s1_xr_q[NBITS-1], s1_xr_q}) + $signed({s1_yr_q[NBITS-1], s1_yr_q});
    assign s2_sum_i = $signed({s1_xi_q[NBITS-1], s1_xi_q}) + $signed({s1_yi_q[NBITS-1], s1_yi_q});
    assign s2_dif_r = $signed({s1_xr_q[NBITS-1], s1_xr_q}) - $signed({s1_yr_q[NBITS-1], s1_yr_q});
    assign s2_dif_i = $signed({s1_xi_q[NBITS-1], s1_xi_q}) - $signed({s1_yi_q[NBITS-1], s1_yi_q});

    // Halving by arithmetic shift floors; a halved 17-bit sum always fits back in NBITS.
    assign s2_ah_r_d = NBITS'(s2_sum_r >>> 1);
    assign s2_ah_i_d = NBITS'(s2_sum_i >>> 1);
    assign s2_dh_r_d = NBITS'(s2_dif_r >>> 1);
    assign s2_dh_i_d = NBITS'(s2_dif_i >>> 1);

    logic             s2_valid_q;
    logic             s2_last_q;
    logic [NBITS-1:0] s2_ah_r_q;
    logic [NBITS-1:0] s2_ah_i_q;
    logic [NBITS-1:0] s2_dh_r_q;
    logic [NBITS-1:0] s2_dh_i_q;
    logic [NBITS-1:0] s2_wr_q;
    logic [NBITS-1:0] s2_wi_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
        end else if (en) begin
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s2_ah_r_q <= s2_ah_r_d;
            s2_ah_i_q <= s2_ah_i_d;
            s2_dh_r_q <= s2_dh_r_d;
            s2_dh_i_q <= s2_dh_i_d;
            s2_wr_q   <= s1_wr_q;
            s2_wi_q   <= s1_wi_q;
        end
    end

    // ---------------------------------------------------------------- stage 3
    logic signed [PW-1:0] s3_p1_full;
    logic signed [PW-1:0] s3_p2_full;
    logic signed [PW-1:0] s3_p3_full;
    logic signed [PW-1:0] s3_p4_full;
    logic signed [EW-1:0] s3_p1_d;
    logic signed [EW-1:0] s3_p2_d;
    logic signed [EW-1:0] s3_p3_d;
    logic signed [EW-1:0] s3_p4_d;

    assign s3_p1_full = PW'($signed(s2_dh_r_q)) * PW'($signed(s2_wr_q));
    assign s3_p2_full = PW'($signed(s2_dh_i_q)) * PW'($signed(s2_wi_q));
    assign s3_p3_full = PW'($signed(s2_dh_i_q)) * PW'($signed(s2_wr_q));
    assign s3_p4_full = PW'($signed(s2_dh_r_q)) * PW'($signed(s2_wi_q));

    // Q1.15 rescale; -1 * -1 gives +1.0, hence the extra bit over NBITS.
    assign s3_p1_d = EW'(s3_p1_full >>> (NBITS - 1));
    assign s3_p2_d = EW'(s3_p2_full >>> (NBITS - 1));
    assign s3_p3_d = EW'(s3_p3_full >>> (NBITS - 1));
    assign s3_p4_d = EW'(s3_p4_full >>> (NBITS - 1));

    logic                 s3_valid_q;
    logic                 s3_last_q;
    logic [NBITS-1:0]     s3_ah_r_q;
    logic [NBITS-1:0]     s3_ah_i_q;
    logic signed [EW-1:0] s3_p1_q;
    logic signed [EW-1:0] s3_p2_q;
    logic signed [EW-1:0] s3_p3_q;
    logic signed [EW-1:0] s3_p4_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s3_valid_q <= 1'b0;
            s3_last_q  <= 1'b0;
        end else if (en) begin
            s3_valid_q <= s2_valid_q;
            s3_last_q  <= s2_last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s3_ah_r_q <= s2_ah_r_q;
            s3_ah_i_q <= s2_ah_i_q;
            s3_p1_q   <= s3_p1_d;
            s3_p2_q   <= s3_p2_d;
            s3_p3_q   <= s3_p3_d;
            s3_p4_q   <= s3_p4_d;
        end
    end

    // ---------------------------------------------------------------- stage 4
    function automatic logic ovf(input logic [BW-1:0] v);
        return (v[BW-1:NBITS-1] != '0) && (v[BW-1:NBITS-1] != '1);
    endfunction

    function automatic logic [NBITS-1:0] clamp(input logic [BW-1:0] v);
        if (!ovf(v)) begin
            return v[NBITS-1:0];
        end else if (v[BW-1]) begin
            return {1'b1, {(NBITS-1){1'b0}}};
        end else begin
            return {1'b0, {(NBITS-1){1'b1}}};
        end
    endfunction

    logic signed [BW-1:0] s4_br_full;
    logic signed [BW-1:0] s4_bi_full;
    logic                 s4_sat;

    assign s4_br_full = BW'(s3_p1_q) + BW'(s3_p2_q);
    assign s4_bi_full = BW'(s3_p3_q) - BW'(s3_p4_q);
    assign s4_sat     = ovf(s4_br_full) || ovf(s4_bi_full);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            Ar        <= '0;
            Ai        <= '0;
            Br        <= '0;
            Bi        <= '0;
        end else if (en) begin
            out_valid <= s3_valid_q;
            out_last  <= s3_last_q;
            Ar        <= s3_ah_r_q;
            Ai        <= s3_ah_i_q;
            Br        <= clamp(s4_br_full);
            Bi        <= clamp(s4_bi_full);
        end
    end

    // Set has priority over clear so a saturation coinciding with sat_clr is not lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (en && s3_valid_q && s4_sat) begin
            sat_flag <= 1'b1;
        end else if (sat_clr) begin
            sat_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ifft_butterfly_dif.sv
// Bench for ifft_butterfly_dif: vector table plus scoreboard, with hand sequences for
// latency, stall, saturation-flag and mid-stream reset behaviour.
module tb_ifft_butterfly_dif;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [15:0] xr, xi, yr, yi, wr, wi;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [15:0] ar, ai, br, bi;
    logic        sat_flag;
    logic        sat_clr;

    always #5 clk = ~clk;

    ifft_butterfly_dif #(.NBITS(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .Xr       (xr),
        .Xi       (xi),
        .Yr       (yr),
        .Yi       (yi),
        .Wr       (wr),
        .Wi       (wi),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .Ar       (ar),
        .Ai       (ai),
        .Br       (br),
        .Bi       (bi),
        .sat_flag (sat_flag),
        .sat_clr  (sat_clr)
    );

    typedef struct {
        logic [15:0] xr, xi, yr, yi, wr, wi;
        logic        last;
    } stim_t;

    typedef struct {
        logic [15:0] ar, ai, br, bi;
        logic        last;
        logic        sat;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    exp_t sb_q[$];
    exp_t pending_exp;
    vec_t tbl[8];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic longint sx(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t   e;
        longint dr, di, p1, p2, p3, p4, bfr, bfi;
        e.ar = 16'(fdiv(sx(s.xr) + sx(s.yr), 2));
        e.ai = 16'(fdiv(sx(s.xi) + sx(s.yi), 2));
        dr   = fdiv(sx(s.xr) - sx(s.yr), 2);
        di   = fdiv(sx(s.xi) - sx(s.yi), 2);
        p1   = fdiv(dr * sx(s.wr), 32768);
        p2   = fdiv(di * sx(s.wi), 32768);
        p3   = fdiv(di * sx(s.wr), 32768);
        p4   = fdiv(dr * sx(s.wi), 32768);
        bfr  = p1 + p2;
        bfi  = p3 - p4;
        e.sat = (bfr > 32767) || (bfr < -32768) || (bfi > 32767) || (bfi < -32768);
        if (bfr > 32767) bfr = 32767;
        if (bfr < -32768) bfr = -32768;
        if (bfi > 32767) bfi = 32767;
        if (bfi < -32768) bfi = -32768;
        e.br   = 16'(bfr);
        e.bi   = 16'(bfi);
        e.last = s.last;
        return e;
    endfunction

    function automatic stim_t mk_stim(input logic [15:0] a, b, c, d, f, g, input logic l);
        stim_t s;
        s.xr = a; s.xi = b; s.yr = c; s.yi = d; s.wr = f; s.wi = g; s.last = l;
        return s;
    endfunction

    function automatic exp_t mk_exp(input logic [15:0] a, b, c, d, input logic l, input logic st);
        exp_t e;
        e.ar = a; e.ai = b; e.br = c; e.bi = d; e.last = l; e.sat = st;
        return e;
    endfunction

    function automatic stim_t rand_stim(input logic l);
        return mk_stim(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                       16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                       16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), l);
    endfunction

    task automatic apply(input stim_t s);
        xr = s.xr; xi = s.xi; yr = s.yr; yi = s.yi; wr = s.wr; wi = s.wi;
        in_last = s.last;
    endtask

    // Scoreboard: push on accepted input, pop on output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (in_valid && in_ready) sb_q.push_back(pending_exp);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: actual Ar=%h Br=%h required none (t=%0t)",
                             ar, br, $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("Ar", 64'(ar), 64'(e.ar));
                    chk("Ai", 64'(ai), 64'(e.ai));
                    chk("Br", 64'(br), 64'(e.br));
                    chk("Bi", 64'(bi), 64'(e.bi));
                    chk("out_last", 64'(out_last), 64'(e.last));
                    if (e.sat) chk("sat_flag_set", 64'(sat_flag), 64'd1);
                end
            end
        end
    end

    task automatic send(input stim_t s, input exp_t e);
        bit ok = 1'b0;
        apply(s);
        pending_exp = e;
        in_valid    = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_accept", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 60 && sb_q.size() != 0; t++) @(posedge clk);
        chk({tag, "_drain_left"}, 64'(sb_q.size()), 64'd0);
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Single sample on an idle pipe: out_valid must rise exactly three edges after accept.
    task automatic lat_check(input vec_t v, input string tag);
        apply(v.s);
        pending_exp = v.e;
        in_valid    = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_valid_n1"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_valid_n2"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_valid_n3"}, 64'(out_valid), 64'd1);
        chk({tag, "_sat_flag"}, 64'(sat_flag), 64'(v.e.sat));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        stim_t s;

        tbl[0] = '{s: mk_stim(16'h0140, 16'h0060, 16'h00C0, 16'h00A0, 16'h7FFF, 16'h0000, 1'b0),
                   e: mk_exp(16'h0100, 16'h0080, 16'h003F, 16'hFFE0, 1'b0, 1'b0)};
        tbl[1] = '{s: mk_stim(16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 1'b0),
                   e: mk_exp(16'h0040, 16'h0000, 16'h0000, 16'hFFC1, 1'b0, 1'b0)};
        tbl[2] = '{s: mk_stim(16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 16'h8000, 16'h8000, 1'b0),
                   e: mk_exp(16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000, 1'b0, 1'b1)};
        s = mk_stim(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h5A82, 16'hA57E, 1'b0);
        tbl[3] = '{s: s, e: model(s)};
        s = mk_stim(16'hFFFF, 16'h0001, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF, 1'b0);
        tbl[4] = '{s: s, e: model(s)};
        s = mk_stim(16'h1234, 16'hFEDC, 16'h0F0F, 16'h8001, 16'h30FC, 16'h7642, 1'b0);
        tbl[5] = '{s: s, e: model(s)};
        s = mk_stim(16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF, 1'b0);
        tbl[6] = '{s: s, e: model(s)};
        s = mk_stim(16'h0333, 16'hFCCD, 16'hF000, 16'h1000, 16'hE783, 16'h18F9, 1'b1);
        tbl[7] = '{s: s, e: model(s)};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        sat_clr   = 1'b0;
        apply(tbl[0].s);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_data", {ar, ai, br, bi}, 64'd0);
        chk("rst_sat_flag", 64'(sat_flag), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        lat_check(tbl[0], "t1");
        drain("t1");

        for (int i = 0; i < 8; i++) send(tbl[i].s, tbl[i].e);
        drain("table");

        chk("t3_flag_sticky", 64'(sat_flag), 64'd1);
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        chk("t3_flag_cleared", 64'(sat_flag), 64'd0);

        apply(tbl[2].s);
        pending_exp = tbl[2].e;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_flag_before_load", 64'(sat_flag), 64'd0);
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        chk("t6_out_valid", 64'(out_valid), 64'd1);
        chk("t6_set_wins", 64'(sat_flag), 64'd1);
        drain("t6");

        fork
            begin
                stim_t rs;
                for (int i = 0; i < 8; i++) begin
                    rs = rand_stim(i == 7);
                    send(rs, model(rs));
                end
            end
            begin
                logic [63:0] snap;
                logic        snap_last;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("t4_stall_in_ready", 64'(in_ready), 64'd0);
                    chk("t4_stall_valid", 64'(out_valid), 64'd1);
                    if (i == 0) begin
                        snap      = {ar, ai, br, bi};
                        snap_last = out_last;
                    end else begin
                        chk("t4_stall_hold", {ar, ai, br, bi}, snap);
                        chk("t4_stall_last_hold", 64'(out_last), 64'(snap_last));
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("t4");

        for (int i = 0; i < 3; i++) begin
            s = rand_stim(1'b0);
            send(s, model(s));
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_data", {ar, ai, br, bi}, 64'd0);
        chk("t5_sat_flag", 64'(sat_flag), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        repeat (8) @(posedge clk);
        #1;
        chk("t5_no_stale", 64'(out_valid), 64'd0);
        lat_check(tbl[0], "t5");
        drain("t5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
